// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register:
// operation modes, burst FSM states and a mode classifier.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_RSV6 = 3'b110,
        MODE_RSV7 = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Only shifts and rotations may be repeated as a burst.
    function automatic logic is_burst_mode(mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL) ||
               (m == MODE_ROR) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: decides when the datapath steps and
// which operation it applies, and counts burst length down.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic          step,
    output mode_e         op,
    output logic          busy,
    output logic          done
);

    state_e        state_q;
    state_e        state_d;
    mode_e         mode_q;
    mode_e         mode_in;
    logic [CW-1:0] cnt_q;
    logic          accept;

    assign mode_in = mode_e'(mode);
    // A start is honoured only in IDLE, with en high, for shift/rotate.
    assign accept = en && start && is_burst_mode(mode_in);

    // State register, latched burst mode and remaining count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && accept) begin
                mode_q <= mode_in;
                cnt_q  <= count;
            end else if (state_q == ST_BURST && en) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (count != '0) ? ST_BURST : ST_DONE;
                end
            end
            ST_BURST: begin
                if (en && cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: step enable, operation select and status flags.
    always_comb begin
        step = 1'b0;
        op   = mode_in;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                step = en && !accept;
            end
            ST_BURST: begin
                step = en;
                op   = mode_q;
                busy = 1'b1;
            end
            ST_DONE: begin
                op   = MODE_HOLD;
                done = 1'b1;
            end
            default: begin
                op = MODE_HOLD;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate and load,
// either one step per cycle or as a counted burst.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
    parameter int               CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic             step;
    mode_e            op;
    logic [WIDTH-1:0] q_nxt;

    shift_burst_ctrl #(
        .CW (CW)
    ) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .start (start),
        .count (count),
        .step  (step),
        .op    (op),
        .busy  (busy),
        .done  (done)
    );

    // Operation selected by the controller; serial inputs are live.
    always_comb begin
        q_nxt = q;
        unique case (op)
            MODE_SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
            MODE_LOAD: q_nxt = pdata;
            MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            default:   q_nxt = q;
        endcase
    end

    // Register update, gated by the controller's step enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INIT;
        end else if (step) begin
            q <= q_nxt;
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg,
// using a 4-bit and an 8-bit instance on shared controls.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic       start = 1'b0;
    logic [3:0] pdata4 = '0;
    logic [2:0] count4 = '0;
    logic [3:0] q4;
    logic       sr4, sl4, busy4, done4;
    logic [7:0] pdata8 = '0;
    logic [3:0] count8 = '0;
    logic [7:0] q8;
    logic       sr8, sl8, busy8, done8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH (4),
        .INIT  (4'b1010)
    ) dut4 (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .pdata  (pdata4),
        .start  (start),
        .count  (count4),
        .q      (q4),
        .sout_r (sr4),
        .sout_l (sl4),
        .busy   (busy4),
        .done   (done4)
    );

    univ_shift_reg #(
        .WIDTH (8)
    ) dut8 (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .pdata  (pdata8),
        .start  (start),
        .count  (count8),
        .q      (q8),
        .sout_r (sr8),
        .sout_l (sl8),
        .busy   (busy8),
        .done   (done8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; start = 1'b1; mode = 3'b001;
        tick();
        rst = 1'b0; start = 1'b0; mode = 3'b000;
        n_cmp++;
        if ({q4, busy4, done4} !== {4'b1010, 2'b00}) begin
            n_err++;
            $display("FAIL reset4: got q=%b b=%b d=%b want 1010 0 0",
                     q4, busy4, done4);
        end
        n_cmp++;
        if ({q8, busy8, done8} !== {8'h00, 2'b00}) begin
            n_err++;
            $display("FAIL reset8: got q=%h b=%b d=%b want 00 0 0",
                     q8, busy8, done8);
        end
    endtask

    task automatic test_manual_shift;
        en = 1'b1; mode = 3'b001; sin_r = 1'b1;
        tick();
        n_cmp++;
        if (q4 !== 4'b1101) begin
            n_err++;
            $display("FAIL shr: got %b want 1101", q4);
        end
        en = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (q4 !== 4'b1101) begin
            n_err++;
            $display("FAIL en_hold: got %b want 1101", q4);
        end
        en = 1'b1; mode = 3'b010; sin_l = 1'b0;
        tick();
        n_cmp++;
        if ({q4, sl4} !== {4'b1010, 1'b1}) begin
            n_err++;
            $display("FAIL shl: got %b sl=%b want 1010 1", q4, sl4);
        end
    endtask

    task automatic test_load_rotate;
        en = 1'b1; mode = 3'b011; pdata4 = 4'b0110;
        tick();
        n_cmp++;
        if (q4 !== 4'b0110) begin
            n_err++;
            $display("FAIL load: got %b want 0110", q4);
        end
        mode = 3'b100;
        tick();
        n_cmp++;
        if ({q4, sr4} !== {4'b0011, 1'b1}) begin
            n_err++;
            $display("FAIL ror: got %b sr=%b want 0011 1", q4, sr4);
        end
        mode = 3'b110;
        tick();
        n_cmp++;
        if (q4 !== 4'b0011) begin
            n_err++;
            $display("FAIL rsv_hold: got %b want 0011", q4);
        end
    endtask

    task automatic test_burst8(input int stall);
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
        en = 1'b1; mode = 3'b011; pdata8 = 8'h81;
        tick();
        mode = 3'b101; count8 = 4'd3; count4 = 3'd0; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000; pdata8 = 8'hFF;
        n_cmp++;
        if ({q8, busy8, done8} !== {8'h81, 2'b10}) begin
            n_err++;
            $display("FAIL b8_start%0d: got q=%h b=%b d=%b want 81 1 0",
                     stall, q8, busy8, done8);
        end
        for (int i = 0; i < 3; i++) begin
            if (stall != 0 && i == 1) begin
                en = 1'b0;
                tick();
                tick();
                en = 1'b1;
                n_cmp++;
                if ({q8, busy8} !== {8'h03, 1'b1}) begin
                    n_err++;
                    $display("FAIL b8_stall: got q=%h b=%b want 03 1",
                             q8, busy8);
                end
            end
            tick();
            n_cmp++;
            if ({q8, busy8, done8} !==
                {exp_q[i], (i < 2), (i == 2)}) begin
                n_err++;
                $display("FAIL b8_step%0d_%0d: got q=%h b=%b d=%b want %h",
                         stall, i, q8, busy8, done8, exp_q[i]);
            end
        end
        tick();
        n_cmp++;
        if ({q8, busy8, done8} !== {8'h0C, 2'b00}) begin
            n_err++;
            $display("FAIL b8_end%0d: got q=%h b=%b d=%b want 0C 0 0",
                     stall, q8, busy8, done8);
        end
    endtask

    task automatic test_start_ignored;
        en = 1'b1; mode = 3'b011; pdata4 = 4'b1001;
        tick();
        mode = 3'b001; count4 = 3'd0; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        n_cmp++;
        if ({q4, busy4, done4} !== {4'b1001, 2'b01}) begin
            n_err++;
            $display("FAIL cnt0: got q=%b b=%b d=%b want 1001 0 1",
                     q4, busy4, done4);
        end
        tick();
        n_cmp++;
        if ({q4, busy4, done4} !== {4'b1001, 2'b00}) begin
            n_err++;
            $display("FAIL cnt0_end: got q=%b b=%b d=%b want 1001 0 0",
                     q4, busy4, done4);
        end
        mode = 3'b011; pdata4 = 4'b0101; count4 = 3'd4; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        n_cmp++;
        if ({q4, busy4, done4} !== {4'b0101, 2'b00}) begin
            n_err++;
            $display("FAIL start_load: got q=%b b=%b d=%b want 0101 0 0",
                     q4, busy4, done4);
        end
    endtask

    task automatic test_rotate_wrap;
        int  cyc;
        en = 1'b1; mode = 3'b011; pdata4 = 4'b0001;
        tick();
        mode = 3'b101; count4 = 3'd5; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 12) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (done4 !== 1'b1 || cyc != 5) begin
            n_err++;
            $display("FAIL wrap_done: got done=%b after %0d want 1 after 5",
                     done4, cyc);
        end
        n_cmp++;
        if (q4 !== 4'b0010) begin
            n_err++;
            $display("FAIL wrap_q: got %b want 0010", q4);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        int ndone;
        en = 1'b1; mode = 3'b011; pdata4 = 4'b0000;
        tick();
        mode = 3'b001; sin_r = 1'b1; count4 = 3'd5; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        tick();
        n_cmp++;
        if ({q4, busy4} !== {4'b1000, 1'b1}) begin
            n_err++;
            $display("FAIL mid_step: got q=%b b=%b want 1000 1", q4, busy4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({q4, busy4, done4} !== {4'b1010, 2'b00}) begin
            n_err++;
            $display("FAIL mid_rst: got q=%b b=%b d=%b want 1010 0 0",
                     q4, busy4, done4);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 === 1'b1 || busy4 === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0 || q4 !== 4'b1010) begin
            n_err++;
            $display("FAIL post_rst: got %0d busy/done cycles q=%b want 0 1010",
                     ndone, q4);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_manual_shift();
        test_load_rotate();
        test_burst8(0);
        test_burst8(1);
        test_start_ignored();
        test_rotate_wrap();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width in bits; legal range 2..64.
REQ-002 Parameter INIT, default {WIDTH{1'b0}}, SHALL set the value q takes on reset.
REQ-003 Parameter CW, default $clog2(WIDTH)+1, SHALL set the width of the burst count; it is not overridden by users.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 en  input  1  SHALL qualify every register update; en=0 holds q and stalls a burst.
REQ-007 mode  input  3  SHALL select the operation: 000 hold, 001 SHR, 010 SHL, 011 LOAD, 100 ROR, 101 ROL, 110/111 hold (reserved).
REQ-008 sin_r  input  1  SHALL be the serial bit entering the MSB on SHR.
REQ-009 sin_l  input  1  SHALL be the serial bit entering the LSB on SHL.
REQ-010 pdata  input  WIDTH  SHALL be the parallel load word.
REQ-011 start  input  1  SHALL request a burst of count operations in the current mode.
REQ-012 count  input  CW  SHALL be the burst length, range 0..2^CW-1.
REQ-013 q  output  WIDTH  SHALL be the register contents.
REQ-014 sout_r / sout_l  output  1 each  SHALL equal q[0] and q[WIDTH-1] combinationally.
REQ-015 busy  output  1  SHALL be high while a burst is in progress.
REQ-016 done  output  1  SHALL pulse high for exactly one cycle when a burst completes.

Function
REQ-017 SHR SHALL compute q <= {sin_r, q[WIDTH-1:1]}; SHL SHALL compute {q[WIDTH-2:0], sin_l}; ROR SHALL compute {q[0], q[WIDTH-1:1]}; ROL SHALL compute {q[WIDTH-2:0], q[WIDTH-1]}; LOAD SHALL compute q <= pdata.
REQ-018 The FSM SHALL have states IDLE, BURST and DONE.
REQ-019 In IDLE with start=0 and en=1, the FSM SHALL apply exactly one mode operation per cycle (manual mode), and latency to q SHALL be 1 cycle.
REQ-020 In IDLE with start=1 and mode in {SHR, SHL, ROR, ROL}, the FSM SHALL latch mode and count, perform no q update in that cycle, and enter BURST if count!=0 or DONE if count==0.
REQ-021 start with mode in {hold, LOAD, reserved} SHALL be ignored and SHALL be treated as a manual operation per REQ-019.
REQ-022 In BURST, each cycle with en=1 SHALL apply the latched operation and decrement the remaining count; a cycle with en=0 SHALL change nothing.
REQ-023 The shift that brings the remaining count from 1 to 0 SHALL be the last, and the FSM SHALL then move to DONE.
REQ-024 In BURST, sin_r and sin_l SHALL be sampled live each cycle, not latched.
REQ-025 DONE SHALL assert done for one cycle, ignore all inputs, and return to IDLE.
REQ-026 busy SHALL be 1 in BURST only; start, mode, count and pdata SHALL be ignored in BURST and DONE.
REQ-027 count values above WIDTH SHALL be legal, and rotations SHALL wrap modulo WIDTH.

Reset
REQ-028 On rst=1 at a clock edge: q=INIT, FSM=IDLE, remaining count=0, busy=0, done=0; rst SHALL override en and start, including in the middle of a burst.

Structure
REQ-029 The mode encodings and the FSM state enum SHALL reside in the shared package shift_pkg.
REQ-030 The burst FSM and down-counter SHALL be one sub-module, shift_burst_ctrl, which outputs a step enable and the latched mode; the datapath SHALL remain in univ_shift_reg.

Verification (WIDTH=4, INIT=4'b1010 unless stated)
REQ-031 Reset: assert rst for 1 cycle -> q=1010, busy=0, done=0.
REQ-032 Manual SHR: en=1, sin_r=1 -> q=1101; then en=0 for 2 cycles -> q holds at 1101; then SHL with sin_l=0 -> q=1010.
REQ-033 LOAD pdata=0110, then ROR x1 -> q=0011, sout_r=1; mode=110 -> q unchanged.
REQ-034 WIDTH=8: LOAD 0x81, then start with ROL and count=3 -> busy for 3 cycles, q=0x03, 0x06, 0x0C, then done for 1 cycle; en low for 2 cycles in mid-burst -> completion delayed by 2 cycles with the same final q.
REQ-035 start with count=0 -> no q change, done pulses on the next cycle, busy stays 0; start with LOAD -> q=pdata, busy stays 0.
REQ-036 rst asserted on the 2nd cycle of a burst with count=5 -> q=INIT, busy=0, done never pulses.
